// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared ALU.
// Each accepted operation walks IDLE -> EXEC -> RESP. Operands are latched
// toward the ALU, and the ALU result is captured one cycle later. The response
// is then held until the consumer takes it.
//
// Optional feature (build macro ALU_ARB_DIVZERO_TRAP_EN):
//   defined   - a divide (Ctrl=1001) with B=0 skips EXEC. It answers directly
//               with Result=all-ones, Zero=0, Err=1.
//   undefined - Out_Rsp_Err is tied to 0, and divide-by-zero goes to the ALU.
//
// Ports:
//   In_CLK, In_Rst_n            clock, synchronous active-low reset
//   In_ReqN_Valid/A/B/Ctrl      requester N operation (N = 0, 1)
//   Out_ReqN_Ready              requester N accepted this cycle (IDLE only)
//   Out_ALU_A/B/Ctrl            latched operands driven to the shared ALU
//   In_ALU_Result/Zero          shared ALU outputs
//   Out_Rsp_Valid/Id/Result/Zero/Err, In_Rsp_Ready   response handshake
module alu_arbiter #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              In_CLK,
    input  logic              In_Rst_n,
    input  logic              In_Req0_Valid,
    input  logic [DATA_W-1:0] In_Req0_A,
    input  logic [DATA_W-1:0] In_Req0_B,
    input  logic [3:0]        In_Req0_Ctrl,
    input  logic              In_Req1_Valid,
    input  logic [DATA_W-1:0] In_Req1_A,
    input  logic [DATA_W-1:0] In_Req1_B,
    input  logic [3:0]        In_Req1_Ctrl,
    output logic              Out_Req0_Ready,
    output logic              Out_Req1_Ready,
    output logic [DATA_W-1:0] Out_ALU_A,
    output logic [DATA_W-1:0] Out_ALU_B,
    output logic [3:0]        Out_ALU_Ctrl,
    input  logic [DATA_W-1:0] In_ALU_Result,
    input  logic              In_ALU_Zero,
    output logic              Out_Rsp_Valid,
    output logic              Out_Rsp_Id,
    output logic [DATA_W-1:0] Out_Rsp_Result,
    output logic              Out_Rsp_Zero,
    output logic              Out_Rsp_Err,
    input  logic              In_Rsp_Ready
);

    localparam int unsigned CTRL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Arbitration and selection
    logic              last_grant;
    logic              grant_any;
    logic              grant_id;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [CTRL_W-1:0] sel_ctrl;
    logic              accept;
    logic              trap;

    // Registered datapath
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;

    // Grant: a lone requester wins outright; on a tie, the one not served last wins
    always_comb begin
        grant_any = In_Req0_Valid | In_Req1_Valid;
        if (In_Req0_Valid && In_Req1_Valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = In_Req1_Valid;
        end
        sel_a    = grant_id ? In_Req1_A    : In_Req0_A;
        sel_b    = grant_id ? In_Req1_B    : In_Req0_B;
        sel_ctrl = grant_id ? In_Req1_Ctrl : In_Req0_Ctrl;
    end

    assign accept = (state == IDLE) && grant_any;

`ifdef ALU_ARB_DIVZERO_TRAP_EN
    localparam logic [CTRL_W-1:0] CTRL_DIV = 4'b1001;

    assign trap = (sel_ctrl == CTRL_DIV) && (sel_b == '0);
`else
    assign trap = 1'b0;
`endif

    // State register
    always_ff @(posedge In_CLK) begin
        if (!In_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_next = trap ? RESP : EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (In_Rsp_Ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Ready is a same-cycle handshake, so it is decoded combinationally from the grant
    always_comb begin
        Out_Req0_Ready = 1'b0;
        Out_Req1_Ready = 1'b0;
        if (In_Rst_n && (state == IDLE) && grant_any) begin
            Out_Req0_Ready = ~grant_id;
            Out_Req1_Ready = grant_id;
        end
    end

    // Operand latch, grant pointer and response capture
    always_ff @(posedge In_CLK) begin
        if (!In_Rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                alu_a      <= sel_a;
                alu_b      <= sel_b;
                alu_ctrl   <= sel_ctrl;
                rsp_id     <= grant_id;
                last_grant <= grant_id;
            end
            // A trapped divide answers straight from IDLE
            if (accept && trap) begin
                rsp_valid  <= 1'b1;
                rsp_result <= '1;
                rsp_zero   <= 1'b0;
            end
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_result <= In_ALU_Result;
                rsp_zero   <= In_ALU_Zero;
            end
            if ((state == RESP) && In_Rsp_Ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_DIVZERO_TRAP_EN
    logic rsp_err;

    // Err follows the trap decision taken at acceptance and is held through RESP
    always_ff @(posedge In_CLK) begin
        if (!In_Rst_n) begin
            rsp_err <= 1'b0;
        end else if (accept) begin
            rsp_err <= trap;
        end
    end

    assign Out_Rsp_Err = rsp_err;
`else
    assign Out_Rsp_Err = 1'b0;
`endif

    assign Out_ALU_A      = alu_a;
    assign Out_ALU_B      = alu_b;
    assign Out_ALU_Ctrl   = alu_ctrl;
    assign Out_Rsp_Valid  = rsp_valid;
    assign Out_Rsp_Id     = rsp_id;
    assign Out_Rsp_Result = rsp_result;
    assign Out_Rsp_Zero   = rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural model of the shared ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic [15:0] a0 = '0;
    logic [15:0] b0 = '0;
    logic [15:0] a1 = '0;
    logic [15:0] b1 = '0;
    logic [3:0]  c0 = '0;
    logic [3:0]  c1 = '0;
    logic        rsp_ready = 1'b0;

    logic        ready0;
    logic        ready1;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_res;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(16)) dut (
        .In_CLK         (clk),
        .In_Rst_n       (rst_n),
        .In_Req0_Valid  (v0),
        .In_Req0_A      (a0),
        .In_Req0_B      (b0),
        .In_Req0_Ctrl   (c0),
        .In_Req1_Valid  (v1),
        .In_Req1_A      (a1),
        .In_Req1_B      (b1),
        .In_Req1_Ctrl   (c1),
        .Out_Req0_Ready (ready0),
        .Out_Req1_Ready (ready1),
        .Out_ALU_A      (alu_a),
        .Out_ALU_B      (alu_b),
        .Out_ALU_Ctrl   (alu_ctrl),
        .In_ALU_Result  (alu_res),
        .In_ALU_Zero    (alu_zero),
        .Out_Rsp_Valid  (rsp_valid),
        .Out_Rsp_Id     (rsp_id),
        .Out_Rsp_Result (rsp_result),
        .Out_Rsp_Zero   (rsp_zero),
        .Out_Rsp_Err    (rsp_err),
        .In_Rsp_Ready   (rsp_ready)
    );

    // Shared ALU: add, sub, divide (0xDEAD on divide-by-zero), xor otherwise
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_res = alu_a + alu_b;
            4'b0001: alu_res = alu_a - alu_b;
            4'b1001: alu_res = (alu_b == 16'd0) ? 16'hDEAD : alu_a / alu_b;
            default: alu_res = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_res == 16'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        rsp_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v0 = 1'b1;
        v1 = 1'b1;
        a0 = 16'h1111;
        b0 = 16'h2222;
        c0 = 4'h3;
        step();
        total++;
        if ({ready0, ready1} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=00", {ready0, ready1});
        end
        total++;
        if ({alu_a, alu_b, alu_ctrl} !== 36'd0) begin
            bad++;
            $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_ctrl});
        end
        total++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== 20'd0) begin
            bad++;
            $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err});
        end
        v0 = 1'b0;
        v1 = 1'b0;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        a0 = 16'd5;
        b0 = 16'd3;
        c0 = 4'b0000;
        v0 = 1'b1;
        rsp_ready = 1'b0;
        #1;
        total++;
        if ({ready0, ready1} !== 2'b10) begin
            bad++;
            $display("FAIL basic_ready got=%b exp=10", {ready0, ready1});
        end
        step();
        v0 = 1'b0;
        #1;
        total++;
        if ({rsp_valid, ready0} !== 2'b00) begin
            bad++;
            $display("FAIL basic_n1 got=%b exp=00", {rsp_valid, ready0});
        end
        total++;
        if ({alu_a, alu_b, alu_ctrl} !== {16'd5, 16'd3, 4'd0}) begin
            bad++;
            $display("FAIL basic_alu got=%h exp=%h", {alu_a, alu_b, alu_ctrl}, {16'd5, 16'd3, 4'd0});
        end
        step();
        total++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 1'b0, 16'd8, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL basic_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err},
                     {1'b1, 1'b0, 16'd8, 1'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        step();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_release got=%b exp=0", rsp_valid);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic        exp_id;
        logic [15:0] exp_res;
        do_reset();
        a0 = 16'd10; b0 = 16'd1; c0 = 4'd0;
        a1 = 16'd20; b1 = 16'd2; c1 = 4'd0;
        v0 = 1'b1;
        v1 = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_id  = (k % 2 == 1);
            exp_res = exp_id ? 16'd22 : 16'd11;
            total++;
            if ({ready0, ready1} !== {~exp_id, exp_id}) begin
                bad++;
                $display("FAIL rr_grant%0d got=%b exp=%b", k, {ready0, ready1}, {~exp_id, exp_id});
            end
            step();
            total++;
            if ({ready0, ready1} !== 2'b00) begin
                bad++;
                $display("FAIL rr_exec_ready%0d got=%b exp=00", k, {ready0, ready1});
            end
            step();
            total++;
            if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, exp_id, exp_res}) begin
                bad++;
                $display("FAIL rr_rsp%0d got=%h exp=%h", k, {rsp_valid, rsp_id, rsp_result}, {1'b1, exp_id, exp_res});
            end
            step();
        end
        v0 = 1'b0;
        v1 = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_hold();
        a0 = 16'd7;
        b0 = 16'd7;
        c0 = 4'b0001;
        v0 = 1'b1;
        rsp_ready = 1'b0;
        #1;
        total++;
        if (ready0 !== 1'b1) begin
            bad++;
            $display("FAIL hold_accept got=%b exp=1", ready0);
        end
        step();
        // A new request arriving mid-operation must be ignored
        a0 = 16'h0F0F;
        b0 = 16'h0001;
        c0 = 4'h0;
        #1;
        total++;
        if (ready0 !== 1'b0) begin
            bad++;
            $display("FAIL hold_exec_ready got=%b exp=0", ready0);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, ready0} !==
                {1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold_stable%0d got=%h exp=%h", i,
                         {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, ready0},
                         {1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0});
            end
            if (i < 3) step();
        end
        rsp_ready = 1'b1;
        step();
        total++;
        if ({rsp_valid, ready0} !== 2'b01) begin
            bad++;
            $display("FAIL hold_idle got=%b exp=01", {rsp_valid, ready0});
        end
        v0 = 1'b0;
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset_exec();
        do_reset();
        a1 = 16'd3; b1 = 16'd4; c1 = 4'd0;
        v1 = 1'b1;
        #1;
        total++;
        if ({ready0, ready1} !== 2'b01) begin
            bad++;
            $display("FAIL rexec_accept got=%b exp=01", {ready0, ready1});
        end
        step();
        v1 = 1'b0;
        rst_n = 1'b0;
        step();
        total++;
        if ({ready0, ready1, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== '0) begin
            bad++;
            $display("FAIL rexec_clear got=%h exp=0",
                     {ready0, ready1, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rexec_norsp%0d got=%b exp=0", i, rsp_valid);
            end
        end
        a0 = 16'd1; b0 = 16'd1; c0 = 4'd0;
        a1 = 16'd2; b1 = 16'd2; c1 = 4'd0;
        v0 = 1'b1;
        v1 = 1'b1;
        #1;
        total++;
        if ({ready0, ready1} !== 2'b10) begin
            bad++;
            $display("FAIL rexec_tie got=%b exp=10", {ready0, ready1});
        end
        step();
        v0 = 1'b0;
        v1 = 1'b0;
        step();
        total++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 16'd2}) begin
            bad++;
            $display("FAIL rexec_tie_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 16'd2});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_divzero();
        do_reset();
        a0 = 16'd100; b0 = 16'd0; c0 = 4'b1001;
        v0 = 1'b1;
        #1;
        total++;
        if (ready0 !== 1'b1) begin
            bad++;
            $display("FAIL div0_accept got=%b exp=1", ready0);
        end
        step();
        v0 = 1'b0;
        #1;
`ifdef ALU_ARB_DIVZERO_TRAP_EN
        total++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL div0_trap got=%h exp=%h", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err},
                     {1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1});
        end
        total++;
        if ({alu_a, alu_b, alu_ctrl, ready0, ready1} !== {16'd100, 16'd0, 4'b1001, 2'b00}) begin
            bad++;
            $display("FAIL div0_alu got=%h exp=%h", {alu_a, alu_b, alu_ctrl, ready0, ready1},
                     {16'd100, 16'd0, 4'b1001, 2'b00});
        end
`else
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL div0_n1 got=%b exp=0", rsp_valid);
        end
        step();
        total++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL div0_pass got=%h exp=%h", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err},
                     {1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0});
        end
`endif
        rsp_ready = 1'b1;
        step();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL div0_release got=%b exp=0", rsp_valid);
        end
        rsp_ready = 1'b0;
        // A divide by a non-zero value takes the normal path in both builds
        a1 = 16'd100; b1 = 16'd4; c1 = 4'b1001;
        v1 = 1'b1;
        #1;
        step();
        v1 = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL div_n1 got=%b exp=0", rsp_valid);
        end
        step();
        total++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err} !== {1'b1, 1'b1, 16'd25, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL div_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err},
                     {1'b1, 1'b1, 16'd25, 1'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_ctrl_pass();
        rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            a0 = 16'h00F0;
            b0 = 16'h0003;
            c0 = 4'(c);
            v0 = 1'b1;
            #1;
            step();
            v0 = 1'b0;
            total++;
            if (alu_ctrl !== 4'(c)) begin
                bad++;
                $display("FAIL ctrl_pass%0d got=%h exp=%h", c, alu_ctrl, 4'(c));
            end
            step();
            total++;
            if (rsp_valid !== 1'b1) begin
                bad++;
                $display("FAIL ctrl_rsp%0d got=%b exp=1", c, rsp_valid);
            end
            step();
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        int   acc_cnt = 0;
        int   rsp_cnt = 0;
        logic prev_acc = 1'b0;
        logic is_acc;
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            a0 = 16'($urandom);
            a1 = 16'($urandom);
            b0 = 16'($urandom_range(0, 3));
            b1 = 16'($urandom_range(0, 3));
            c0 = 4'($urandom);
            c1 = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if ((ready0 && !v0) || (ready1 && !v1) || (ready0 && ready1) ||
                ((ready0 || ready1) && (prev_acc || rsp_valid))) begin
                bad++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=no-grant-while-busy", cyc, {ready0, ready1});
            end
            is_acc = (v0 && ready0) || (v1 && ready1);
            if (is_acc) acc_cnt++;
            if (rsp_valid && rsp_ready) rsp_cnt++;
            total++;
            if ((acc_cnt - rsp_cnt) > 1 || (acc_cnt - rsp_cnt) < 0) begin
                bad++;
                $display("FAIL rand_outstanding cyc=%0d got=%0d exp=0..1", cyc, acc_cnt - rsp_cnt);
            end
            prev_acc = is_acc;
            step();
        end
        v0 = 1'b0;
        v1 = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rsp_valid && rsp_ready) rsp_cnt++;
            step();
        end
        total++;
        if (acc_cnt !== rsp_cnt || acc_cnt == 0) begin
            bad++;
            $display("FAIL rand_count got=%0d rsp exp=%0d (accepted)", rsp_cnt, acc_cnt);
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_hold();
        test_reset_exec();
        test_divzero();
        test_ctrl_pass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width; only 16 supported.
REQ-002 SHALL have port In_CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port In_Rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports In_Req0_Valid / In_Req1_Valid  input  1  requester operation valid.
REQ-005 SHALL have ports In_Req0_A, In_Req0_B, In_Req1_A, In_Req1_B  input  16  operands.
REQ-006 SHALL have ports In_Req0_Ctrl / In_Req1_Ctrl  input  4  ALU control code.
REQ-007 SHALL have ports Out_Req0_Ready / Out_Req1_Ready  output  1  request accepted this cycle.
REQ-008 SHALL have ports Out_ALU_A, Out_ALU_B  output  16, Out_ALU_Ctrl  output  4  to shared ALU.
REQ-009 SHALL have ports In_ALU_Result  input  16, In_ALU_Zero  input  1  from shared ALU.
REQ-010 SHALL have ports Out_Rsp_Valid  output  1, Out_Rsp_Id  output  1 (requester), Out_Rsp_Result  output  16, Out_Rsp_Zero  output  1, Out_Rsp_Err  output  1.
REQ-011 SHALL have port In_Rsp_Ready  input  1  consumer accepts response.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 In IDLE, grant: only one valid -> that requester; both valid -> requester not granted last (round-robin); none -> no grant.
REQ-014 Out_ReqN_Ready SHALL be 1 only in IDLE for the granted requester; 0 in EXEC and RESP.
REQ-015 On acceptance (Valid & Ready) SHALL latch A, B, Ctrl, requester id, update last-grant pointer, go to EXEC.
REQ-016 Out_ALU_A/B/Ctrl SHALL be driven from latched registers and hold them until next acceptance.
REQ-017 In EXEC (exactly one cycle) SHALL capture In_ALU_Result and In_ALU_Zero into response registers and go to RESP.
REQ-018 In RESP Out_Rsp_Valid SHALL be 1; Id/Result/Zero/Err SHALL stay stable until In_Rsp_Ready=1.
REQ-019 RESP with In_Rsp_Ready=1 SHALL go to IDLE, deassert Out_Rsp_Valid next cycle; no acceptance in that same cycle.
REQ-020 Latency: accept at cycle n -> Out_Rsp_Valid at n+2; max throughput one op per 3 cycles.
REQ-021 Requester with Valid deasserted before acceptance SHALL NOT be served; inputs ignored outside IDLE.
REQ-022 All Ctrl codes 0000-1111 SHALL pass unmodified; arbiter performs no arithmetic except per REQ-027.

Reset
REQ-023 In_Rst_n=0 at a rising edge SHALL force IDLE, last-grant pointer=1 (Req0 wins first tie).
REQ-024 Reset SHALL clear all outputs to 0: Ready, ALU A/B/Ctrl, Rsp Valid/Id/Result/Zero/Err.
REQ-025 Reset in EXEC or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-026 Macro ALU_ARB_DIVZERO_TRAP_EN SHALL select divide-by-zero trapping.
REQ-027 Defined: accepted op with Ctrl=1001 and B=0 SHALL skip EXEC, go IDLE->RESP, Result=16'hFFFF, Zero=0, Err=1, ALU outputs still latched; otherwise Err=0.
REQ-028 Undefined: Out_Rsp_Err SHALL be constant 0; divide-by-zero passes to ALU like any op.

Verification
REQ-029 Req0 only, A=5,B=3,Ctrl=0000, ALU model returns 8 -> Rsp Valid at n+2, Id=0, Result=8, Zero=0.
REQ-030 Both valid every cycle after reset -> grant order Req0, Req1, Req0, Req1.
REQ-031 Result 0 (A=7,B=7,Ctrl=0001) with In_Rsp_Ready=0 for 4 cycles -> Valid, Result=0, Zero=1 stable 4 cycles, IDLE one cycle after Ready.
REQ-032 Reset asserted in EXEC -> next cycle all outputs 0, no response; Req1 then wins nothing over Req0 tie.
REQ-033 Ctrl=1001, B=0: macro defined -> Valid at n+1, Result=16'hFFFF, Err=1; undefined -> ALU result at n+2, Err=0.
REQ-034 Ready never asserted in EXEC/RESP across random valid stimulus; every accepted op yields exactly one response.
